// File: rtl/mul_div_param.sv
// Iterative multiply/divide unit: two-cycle multiply, W-cycle restoring divide, sign fix-up.
// Optional macro MUL_DIV_FAST_EXCEPTION_EN finishes divide-by-zero / signed overflow in one cycle.
module mul_div_param #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_in,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [2:0]            op,
  output logic                  busy,
  output logic                  enable_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_by_zero,
  output logic                  ov,
  output logic [2:0]            state_o
);
  // Handshake: a request is taken on a rising edge where enable_in=1 and busy=0;
  // enable_out is high for exactly the DONE cycle, and a new request may be taken then.
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          rneg_q, rneg_d;
  logic          pdbz_q, pdbz_d;
  logic          pov_q, pov_d;
  logic [W-1:0]  result_q, result_d;
  logic          dbz_q, dbz_d;
  logic          ov_q, ov_d;

  logic          x_signed, y_signed, xs, ys;
  logic [W-1:0]  mag_x, mag_y;
  logic          req_dbz, req_ov;
  logic [W:0]    shifted, trial;
  logic [2*W-1:0] prod_fixed;
  logic [W-1:0]  quo_fixed, rem_fixed;

  function automatic logic [W-1:0] exc_value(input logic [2:0] o, input logic [W-1:0] xv,
                                             input logic is_dbz);
    if (is_dbz) exc_value = o[1] ? xv : '1;
    else        exc_value = o[1] ? '0 : xv;
  endfunction

  // MUL/MULH both signed, MULHSU x only, DIV/REM both; unsigned variants neither.
  assign x_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op[2] && !op[0]);
  assign y_signed = (op == 3'b000) || (op == 3'b001) || (op[2] && !op[0]);
  assign xs       = x_signed && x[W-1];
  assign ys       = y_signed && y[W-1];
  assign mag_x    = xs ? (~x + 1'b1) : x;
  assign mag_y    = ys ? (~y + 1'b1) : y;
  assign req_dbz  = op[2] && (y == '0);
  assign req_ov   = op[2] && !op[0] && (x == {1'b1, {(W-1){1'b0}}}) && (y == '1);

  assign shifted    = {rem_q, a_q[W-1]};
  assign trial      = shifted - {1'b0, b_q};
  assign prod_fixed = neg_q ? (~prod_q + 1'b1) : prod_q;
  assign quo_fixed  = neg_q ? (~a_q + 1'b1) : a_q;
  assign rem_fixed  = rneg_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    pdbz_d   = pdbz_q;
    pov_d    = pov_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ov_d     = ov_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (enable_in) begin
          op_d   = op;
          x_d    = x;
          a_d    = mag_x;
          b_d    = mag_y;
          neg_d  = xs ^ ys;
          rneg_d = xs;
          pdbz_d = req_dbz;
          pov_d  = req_ov;
          rem_d  = '0;
          cnt_d  = '0;
          if (!op[2]) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DIV;
`ifdef MUL_DIV_FAST_EXCEPTION_EN
            if (req_dbz || req_ov) begin
              state_d  = S_DONE;
              result_d = exc_value(op, x, req_dbz);
              dbz_d    = req_dbz;
              ov_d     = req_ov;
            end
`endif
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          prod_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
          cnt_d  = CW'(1);
        end else begin
          result_d = (op_q[1:0] == 2'b00) ? prod_fixed[W-1:0] : prod_fixed[2*W-1:W];
          dbz_d    = 1'b0;
          ov_d     = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        // Restoring step: quotient bits shift into a_q as dividend bits shift out.
        rem_d = trial[W] ? shifted[W-1:0] : trial[W-1:0];
        a_d   = {a_q[W-2:0], ~trial[W]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (pdbz_q || pov_q) result_d = exc_value(op_q, x_q, pdbz_q);
        else                 result_d = op_q[1] ? rem_fixed : quo_fixed;
        dbz_d   = pdbz_q;
        ov_d    = pov_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      x_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      pdbz_q   <= 1'b0;
      pov_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      pdbz_q   <= pdbz_d;
      pov_q    <= pov_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ov_q     <= ov_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign enable_out  = (state_q == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign ov          = ov_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_mul_div_param.sv
// Directed bench for mul_div_param at W=32: vector table plus back-to-back, busy-ignore and reset-abort sequences.
module tb_mul_div_param;
  localparam int W = 32;
`ifdef MUL_DIV_FAST_EXCEPTION_EN
  localparam int EXC_LAT = 1;
`else
  localparam int EXC_LAT = 34;
`endif
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable_in = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [2:0]   op = '0;
  logic         busy, enable_out, div_by_zero, ov;
  logic [W-1:0] result;
  logic [2:0]   state_o;

  int total = 0;
  int bad   = 0;

  mul_div_param #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .enable_in(enable_in), .x(x), .y(y), .op(op),
    .busy(busy), .enable_out(enable_out), .result(result),
    .div_by_zero(div_by_zero), .ov(ov), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
    logic         dbz;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (!enable_out && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input string nm, input vec_t v);
    int n;
    @(negedge clk);
    op = v.op; x = v.x; y = v.y; enable_in = 1'b1;
    @(negedge clk);
    enable_in = 1'b0;
    if (v.lat > 1) chk({nm, "_busy"}, 64'(busy), 64'd1);
    wait_done(1, n);
    chk({nm, "_lat"}, 64'(n), 64'(v.lat));
    chk({nm, "_res"}, 64'(result), 64'(v.res));
    chk({nm, "_dbz"}, 64'(div_by_zero), 64'(v.dbz));
    chk({nm, "_ov"},  64'(ov), 64'(v.ov));
  endtask

  initial begin
    int n;
    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b0, MUL_LAT};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, MUL_LAT};
    vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, MUL_LAT};
    vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, MUL_LAT};
    vecs[4]  = '{3'b000, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 1'b0, MUL_LAT};
    vecs[5]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 1'b0, MUL_LAT};
    vecs[6]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, MUL_LAT};
    vecs[7]  = '{3'b011, 32'h00000002, 32'h00000003, 32'h00000000, 1'b0, 1'b0, MUL_LAT};
    vecs[8]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, DIV_LAT};
    vecs[9]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, DIV_LAT};
    vecs[10] = '{3'b101, 32'h80000000, 32'h00000003, 32'h2AAAAAAA, 1'b0, 1'b0, DIV_LAT};
    vecs[11] = '{3'b111, 32'h80000000, 32'h00000003, 32'h00000002, 1'b0, 1'b0, DIV_LAT};
    vecs[12] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, DIV_LAT};
    vecs[13] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, DIV_LAT};
    vecs[14] = '{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0, DIV_LAT};
    vecs[15] = '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b0, DIV_LAT};
    vecs[16] = '{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, EXC_LAT};
    vecs[17] = '{3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1, 1'b0, EXC_LAT};
    vecs[18] = '{3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, EXC_LAT};
    vecs[19] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, EXC_LAT};
    vecs[20] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, EXC_LAT};
    vecs[21] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, DIV_LAT};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_eout", 64'(enable_out), 64'd0);
    chk("rst_res",  64'(result), 64'd0);
    chk("rst_dbz",  64'(div_by_zero), 64'd0);
    chk("rst_ov",   64'(ov), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) do_op($sformatf("v%0d", i), vecs[i]);

    // Multiply flags must clear after an exception result.
    do_op("mul_after_exc", vecs[4]);

    // Back-to-back: DIV accepted in the DONE cycle of a MUL.
    @(negedge clk);
    op = 3'b000; x = 32'd7; y = 32'd6; enable_in = 1'b1;
    @(negedge clk);
    enable_in = 1'b0;
    wait_done(1, n);
    chk("b2b_mul_lat", 64'(n), 64'(MUL_LAT));
    chk("b2b_mul_res", 64'(result), 64'h2A);
    op = 3'b100; x = 32'hFFFFFFF9; y = 32'd2; enable_in = 1'b1;
    @(negedge clk);
    enable_in = 1'b0;
    chk("b2b_div_state", 64'(state_o), 64'd2);
    wait_done(1, n);
    chk("b2b_div_lat", 64'(n), 64'(DIV_LAT));
    chk("b2b_div_res", 64'(result), 64'hFFFFFFFD);

    // Requests while busy are ignored.
    @(negedge clk);
    op = 3'b101; x = 32'd100; y = 32'd7; enable_in = 1'b1;
    @(negedge clk);
    op = 3'b000; x = 32'd3; y = 32'd3;
    n = 1;
    repeat (6) begin
      @(negedge clk);
      n++;
    end
    enable_in = 1'b0;
    wait_done(n, n);
    chk("ign_lat", 64'(n), 64'(DIV_LAT));
    chk("ign_res", 64'(result), 64'hE);

    // Reset sampled at cycle N+10 of a divide aborts it.
    @(negedge clk);
    op = 3'b101; x = 32'd100; y = 32'd7; enable_in = 1'b1;
    @(negedge clk);
    enable_in = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res",  64'(result), 64'd0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (enable_out) n++;
    end
    chk("abort_no_eout", 64'(n), 64'd0);
    reset_n = 1'b1;
    op = 3'b011; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; enable_in = 1'b1;
    @(negedge clk);
    enable_in = 1'b0;
    chk("post_rst_busy", 64'(busy), 64'd1);
    wait_done(1, n);
    chk("post_rst_lat", 64'(n), 64'(MUL_LAT));
    chk("post_rst_res", 64'(result), 64'hFFFFFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
